// File: rtl/d_branch_sched_if.sv
// Decode-stage control-transfer bus between the pipeline D stage and the branch scheduler.
// The master is the pipeline side; the slave is the scheduler.
interface d_branch_sched_if;
  logic        D_valid;
  logic [2:0]  D_br_type;
  logic [31:0] D_PC;
  logic [15:0] D_imm16;
  logic [25:0] D_index;
  logic [31:0] D_RD1;
  logic [31:0] D_RD2;
  logic        D_rs_ready;
  logic        D_rt_ready;
  logic        D_hold;
  logic        D_stall;
  logic [1:0]  D_npc_sel;
  logic [31:0] D_npc;
  logic        D_taken;
  logic        D_link_we;
  logic        D_err;

  modport master (
    output D_valid, D_br_type, D_PC, D_imm16, D_index, D_RD1, D_RD2,
           D_rs_ready, D_rt_ready, D_hold,
    input  D_stall, D_npc_sel, D_npc, D_taken, D_link_we, D_err
  );

  modport slave (
    input  D_valid, D_br_type, D_PC, D_imm16, D_index, D_RD1, D_RD2,
           D_rs_ready, D_rt_ready, D_hold,
    output D_stall, D_npc_sel, D_npc, D_taken, D_link_we, D_err
  );
endinterface

// File: rtl/d_branch_sched.sv
// Decode-stage branch/jump scheduler: waits for forwarded operands, resolves the
// transfer, latches the decision while D is frozen, and counts taken/stall events.
module d_branch_sched #(
  parameter int WAIT_LIMIT = 3,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  d_branch_sched_if.slave  bus,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int WCW = $clog2(WAIT_LIMIT + 2);
  localparam logic [WCW-1:0] WAIT_SAT = WCW'(WAIT_LIMIT + 1);

  localparam logic [2:0] BR_BEQ = 3'b001;
  localparam logic [2:0] BR_BNE = 3'b010;
  localparam logic [2:0] BR_BPJ = 3'b011;
  localparam logic [2:0] BR_JAL = 3'b100;
  localparam logic [2:0] BR_JR  = 3'b101;

  localparam logic [1:0] NPC_SEQ = 2'b00;
  localparam logic [1:0] NPC_BR  = 2'b01;
  localparam logic [1:0] NPC_J   = 2'b10;
  localparam logic [1:0] NPC_REG = 2'b11;

  typedef enum logic [1:0] {IDLE, WAIT, HELD} state_e;

  state_e           state_q, state_d;
  logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
  logic             err_q, err_d;
  logic [1:0]       held_sel_q, held_sel_d;
  logic [31:0]      held_npc_q, held_npc_d;
  logic             held_taken_q, held_taken_d;
  logic             held_link_q, held_link_d;
  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic [31:0] pc_plus4, br_target, j_target;
  logic        is_xfer, need_rs, need_rt, ready, cond;
  logic [1:0]  live_sel;
  logic [31:0] live_npc;
  logic        live_link;

  logic        stall_o, taken_o, link_o, resolve;
  logic [1:0]  sel_o;
  logic [31:0] npc_o;

  // Live decision for whatever instruction currently sits in D.
  always_comb begin
    pc_plus4  = bus.D_PC + 32'd4;
    br_target = pc_plus4 + {{14{bus.D_imm16[15]}}, bus.D_imm16, 2'b00};
    j_target  = {bus.D_PC[31:28], bus.D_index, 2'b00};
    is_xfer   = 1'b0;
    need_rs   = 1'b0;
    need_rt   = 1'b0;
    cond      = 1'b0;
    live_sel  = NPC_SEQ;
    live_link = 1'b0;
    case (bus.D_br_type)
      BR_BEQ: begin
        is_xfer = 1'b1; need_rs = 1'b1; need_rt = 1'b1;
        cond    = (bus.D_RD1 == bus.D_RD2);
        if (cond) live_sel = NPC_BR;
      end
      BR_BNE: begin
        is_xfer = 1'b1; need_rs = 1'b1; need_rt = 1'b1;
        cond    = (bus.D_RD1 != bus.D_RD2);
        if (cond) live_sel = NPC_BR;
      end
      BR_BPJ: begin
        is_xfer = 1'b1; need_rs = 1'b1;
        cond    = ~(^bus.D_RD1);
        if (cond) live_sel = NPC_BR;
        live_link = cond;
      end
      BR_JAL: begin
        is_xfer = 1'b1; cond = 1'b1; live_sel = NPC_J; live_link = 1'b1;
      end
      BR_JR: begin
        is_xfer = 1'b1; need_rs = 1'b1; cond = 1'b1; live_sel = NPC_REG;
      end
      default: ;
    endcase
    is_xfer = is_xfer & bus.D_valid;
    ready   = (~need_rs | bus.D_rs_ready) & (~need_rt | bus.D_rt_ready);
    case (live_sel)
      NPC_BR:  live_npc = br_target;
      NPC_J:   live_npc = j_target;
      NPC_REG: live_npc = bus.D_RD1;
      default: live_npc = pc_plus4;
    endcase
  end

  // Next-state and output selection; reset forces the quiet output set.
  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = '0;
    err_d        = err_q;
    held_sel_d   = held_sel_q;
    held_npc_d   = held_npc_q;
    held_taken_d = held_taken_q;
    held_link_d  = held_link_q;
    stall_o      = 1'b0;
    sel_o        = NPC_SEQ;
    npc_o        = pc_plus4;
    taken_o      = 1'b0;
    link_o       = 1'b0;
    resolve      = 1'b0;
    unique case (state_q)
      IDLE, WAIT: begin
        state_d = IDLE;
        if (is_xfer) begin
          if (!ready) begin
            stall_o    = 1'b1;
            state_d    = WAIT;
            wait_cnt_d = (wait_cnt_q == WAIT_SAT) ? WAIT_SAT : wait_cnt_q + WCW'(1);
          end else begin
            resolve = 1'b1;
            sel_o   = live_sel;
            npc_o   = live_npc;
            taken_o = cond;
            link_o  = live_link;
            if (bus.D_hold) begin
              state_d      = HELD;
              held_sel_d   = live_sel;
              held_npc_d   = live_npc;
              held_taken_d = cond;
              held_link_d  = live_link;
            end
          end
        end
      end
      HELD: begin
        if (bus.D_valid) begin
          sel_o   = held_sel_q;
          npc_o   = held_npc_q;
          taken_o = held_taken_q;
          link_o  = held_link_q;
          if (!bus.D_hold) state_d = IDLE;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (wait_cnt_d > WCW'(WAIT_LIMIT)) err_d = 1'b1;
    if (reset) begin
      stall_o = 1'b0;
      sel_o   = NPC_SEQ;
      npc_o   = pc_plus4;
      taken_o = 1'b0;
      link_o  = 1'b0;
      resolve = 1'b0;
    end
    taken_cnt_d = taken_cnt_q;
    if (resolve && cond && (taken_cnt_q != '1)) taken_cnt_d = taken_cnt_q + CNT_W'(1);
    stall_cnt_d = stall_cnt_q;
    if (stall_o && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      wait_cnt_q   <= '0;
      err_q        <= 1'b0;
      held_sel_q   <= NPC_SEQ;
      held_npc_q   <= '0;
      held_taken_q <= 1'b0;
      held_link_q  <= 1'b0;
      taken_cnt_q  <= '0;
      stall_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      err_q        <= err_d;
      held_sel_q   <= held_sel_d;
      held_npc_q   <= held_npc_d;
      held_taken_q <= held_taken_d;
      held_link_q  <= held_link_d;
      taken_cnt_q  <= taken_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign bus.D_stall   = stall_o;
  assign bus.D_npc_sel = sel_o;
  assign bus.D_npc     = npc_o;
  assign bus.D_taken   = taken_o;
  assign bus.D_link_we = link_o;
  assign bus.D_err     = err_q;
  assign taken_cnt     = taken_cnt_q;
  assign stall_cnt     = stall_cnt_q;

endmodule

// File: tb/tb_d_branch_sched.sv
// Directed bench for d_branch_sched: inputs change just after each rising edge,
// combinational outputs are sampled 1ns later, registered counters after the edge.
module tb_d_branch_sched;
  logic        clk;
  logic        reset;
  logic [15:0] taken_cnt;
  logic [15:0] stall_cnt;
  int          checks;
  int          failures;

  d_branch_sched_if bus ();

  d_branch_sched #(.WAIT_LIMIT(3), .CNT_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .taken_cnt (taken_cnt),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic valid, input logic [2:0] br_type, input logic [31:0] pc,
                       input logic [15:0] imm, input logic [25:0] idx,
                       input logic [31:0] rd1, input logic [31:0] rd2,
                       input logic rs_rdy, input logic rt_rdy, input logic hold);
    bus.D_valid    = valid;
    bus.D_br_type  = br_type;
    bus.D_PC       = pc;
    bus.D_imm16    = imm;
    bus.D_index    = idx;
    bus.D_RD1      = rd1;
    bus.D_RD2      = rd2;
    bus.D_rs_ready = rs_rdy;
    bus.D_rt_ready = rt_rdy;
    bus.D_hold     = hold;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, 3'b000, 32'h0, 16'h0, 26'h0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b1, 3'b001, 32'h1000, 16'h0004, 26'h0, 32'h1, 32'h1, 1'b0, 1'b0, 1'b0);
    checks++; if (bus.D_stall !== 1'b0) begin failures++; $display("[TB] FAIL rst_stall got=%0b exp=0", bus.D_stall); end
    checks++; if (bus.D_npc_sel !== 2'b00) begin failures++; $display("[TB] FAIL rst_sel got=%0b exp=00", bus.D_npc_sel); end
    checks++; if (bus.D_taken !== 1'b0 || bus.D_link_we !== 1'b0) begin failures++; $display("[TB] FAIL rst_taken_link got=%0b%0b exp=00", bus.D_taken, bus.D_link_we); end
    next_cycle();
    reset = 1'b0;
    drive(1'b0, 3'b000, 32'h2000, 16'h0, 26'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    checks++; if (taken_cnt !== 16'd0 || stall_cnt !== 16'd0) begin failures++; $display("[TB] FAIL rst_cnt got=%0d/%0d exp=0/0", taken_cnt, stall_cnt); end
    checks++; if (bus.D_err !== 1'b0) begin failures++; $display("[TB] FAIL rst_err got=%0b exp=0", bus.D_err); end
    checks++; if (bus.D_npc !== 32'h2004) begin failures++; $display("[TB] FAIL idle_npc got=%h exp=00002004", bus.D_npc); end
  endtask

  task automatic test_beq_bne();
    do_reset();
    drive(1'b1, 3'b001, 32'h3000, 16'h0004, 26'h0, 32'd5, 32'd5, 1'b1, 1'b1, 1'b0);
    checks++; if (bus.D_npc_sel !== 2'b01) begin failures++; $display("[TB] FAIL beq_sel got=%0b exp=01", bus.D_npc_sel); end
    checks++; if (bus.D_npc !== 32'h3014) begin failures++; $display("[TB] FAIL beq_npc got=%h exp=00003014", bus.D_npc); end
    checks++; if (bus.D_taken !== 1'b1 || bus.D_stall !== 1'b0) begin failures++; $display("[TB] FAIL beq_taken_stall got=%0b%0b exp=10", bus.D_taken, bus.D_stall); end
    next_cycle();
    drive(1'b1, 3'b001, 32'h3000, 16'h0004, 26'h0, 32'd5, 32'd6, 1'b1, 1'b1, 1'b0);
    checks++; if (taken_cnt !== 16'd1) begin failures++; $display("[TB] FAIL beq_taken_cnt got=%0d exp=1", taken_cnt); end
    checks++; if (bus.D_npc_sel !== 2'b00 || bus.D_npc !== 32'h3004 || bus.D_taken !== 1'b0) begin failures++; $display("[TB] FAIL beq_nt got sel=%0b npc=%h t=%0b exp sel=00 npc=00003004 t=0", bus.D_npc_sel, bus.D_npc, bus.D_taken); end
    next_cycle();
    drive(1'b1, 3'b010, 32'h3000, 16'hFFFC, 26'h0, 32'd5, 32'd6, 1'b1, 1'b1, 1'b0);
    checks++; if (bus.D_npc_sel !== 2'b01 || bus.D_npc !== 32'h2FF4) begin failures++; $display("[TB] FAIL bne_back got sel=%0b npc=%h exp sel=01 npc=00002ff4", bus.D_npc_sel, bus.D_npc); end
    next_cycle();
    drive(1'b0, 3'b000, 32'h0, 16'h0, 26'h0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
    checks++; if (taken_cnt !== 16'd2) begin failures++; $display("[TB] FAIL bne_taken_cnt got=%0d exp=2", taken_cnt); end
  endtask

  task automatic test_bpj();
    do_reset();
    drive(1'b1, 3'b011, 32'h4000, 16'h0010, 26'h0, 32'h7, 32'h0, 1'b1, 1'b0, 1'b0);
    checks++; if (bus.D_npc_sel !== 2'b00 || bus.D_npc !== 32'h4004 || bus.D_link_we !== 1'b0 || bus.D_taken !== 1'b0) begin failures++; $display("[TB] FAIL bpj_odd got sel=%0b npc=%h l=%0b t=%0b exp sel=00 npc=00004004 l=0 t=0", bus.D_npc_sel, bus.D_npc, bus.D_link_we, bus.D_taken); end
    next_cycle();
    drive(1'b1, 3'b011, 32'h4000, 16'h0010, 26'h0, 32'h3, 32'h0, 1'b1, 1'b0, 1'b0);
    checks++; if (bus.D_npc_sel !== 2'b01 || bus.D_npc !== 32'h4044 || bus.D_link_we !== 1'b1 || bus.D_taken !== 1'b1) begin failures++; $display("[TB] FAIL bpj_even got sel=%0b npc=%h l=%0b t=%0b exp sel=01 npc=00004044 l=1 t=1", bus.D_npc_sel, bus.D_npc, bus.D_link_we, bus.D_taken); end
    next_cycle();
    drive(1'b1, 3'b011, 32'h4000, 16'h0010, 26'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    checks++; if (bus.D_taken !== 1'b1 || bus.D_link_we !== 1'b1) begin failures++; $display("[TB] FAIL bpj_zero got t=%0b l=%0b exp t=1 l=1", bus.D_taken, bus.D_link_we); end
    next_cycle();
    drive(1'b0, 3'b000, 32'h0, 16'h0, 26'h0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
    checks++; if (taken_cnt !== 16'd2) begin failures++; $display("[TB] FAIL bpj_taken_cnt got=%0d exp=2", taken_cnt); end
  endtask

  task automatic test_jr_wait();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 3'b101, 32'h5000, 16'h0, 26'h0, 32'h3400, 32'h0, 1'b0, 1'b0, 1'b0);
      checks++; if (bus.D_stall !== 1'b1) begin failures++; $display("[TB] FAIL jr_stall%0d got=%0b exp=1", i, bus.D_stall); end
      next_cycle();
    end
    drive(1'b1, 3'b101, 32'h5000, 16'h0, 26'h0, 32'h3400, 32'h0, 1'b1, 1'b0, 1'b0);
    checks++; if (bus.D_stall !== 1'b0 || bus.D_npc_sel !== 2'b11 || bus.D_npc !== 32'h3400) begin failures++; $display("[TB] FAIL jr_resolve got st=%0b sel=%0b npc=%h exp st=0 sel=11 npc=00003400", bus.D_stall, bus.D_npc_sel, bus.D_npc); end
    checks++; if (stall_cnt !== 16'd2) begin failures++; $display("[TB] FAIL jr_stall_cnt got=%0d exp=2", stall_cnt); end
    checks++; if (bus.D_err !== 1'b0) begin failures++; $display("[TB] FAIL jr_err got=%0b exp=0", bus.D_err); end
    next_cycle();
  endtask

  task automatic test_wait_overrun();
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 3'b010, 32'h6000, 16'h0008, 26'h0, 32'd1, 32'd2, 1'b0, 1'b1, 1'b0);
      checks++; if (bus.D_stall !== 1'b1 || bus.D_err !== (i >= 5)) begin failures++; $display("[TB] FAIL ovr_cycle%0d got st=%0b err=%0b exp st=1 err=%0b", i, bus.D_stall, bus.D_err, (i >= 5)); end
      next_cycle();
    end
    drive(1'b1, 3'b010, 32'h6000, 16'h0008, 26'h0, 32'd1, 32'd2, 1'b1, 1'b1, 1'b0);
    checks++; if (bus.D_stall !== 1'b0 || bus.D_npc !== 32'h6024 || bus.D_err !== 1'b1) begin failures++; $display("[TB] FAIL ovr_resolve got st=%0b npc=%h err=%0b exp st=0 npc=00006024 err=1", bus.D_stall, bus.D_npc, bus.D_err); end
    next_cycle();
    drive(1'b0, 3'b000, 32'h0, 16'h0, 26'h0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
    checks++; if (bus.D_err !== 1'b1 || stall_cnt !== 16'd5) begin failures++; $display("[TB] FAIL ovr_sticky got err=%0b sc=%0d exp err=1 sc=5", bus.D_err, stall_cnt); end
  endtask

  task automatic test_hold();
    do_reset();
    drive(1'b1, 3'b001, 32'h3000, 16'h0004, 26'h0, 32'd9, 32'd9, 1'b1, 1'b1, 1'b1);
    checks++; if (bus.D_npc_sel !== 2'b01 || bus.D_taken !== 1'b1) begin failures++; $display("[TB] FAIL hold_resolve got sel=%0b t=%0b exp sel=01 t=1", bus.D_npc_sel, bus.D_taken); end
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 3'b001, 32'h3000, 16'h0004, 26'h0, 32'd1, 32'd2, 1'b1, 1'b1, (i < 2));
      checks++; if (bus.D_npc_sel !== 2'b01 || bus.D_taken !== 1'b1 || bus.D_npc !== 32'h3014 || bus.D_stall !== 1'b0) begin failures++; $display("[TB] FAIL hold_latched%0d got sel=%0b t=%0b npc=%h st=%0b exp sel=01 t=1 npc=00003014 st=0", i, bus.D_npc_sel, bus.D_taken, bus.D_npc, bus.D_stall); end
      next_cycle();
    end
    drive(1'b1, 3'b001, 32'h3000, 16'h0004, 26'h0, 32'd1, 32'd2, 1'b1, 1'b1, 1'b0);
    checks++; if (bus.D_npc_sel !== 2'b00 || bus.D_taken !== 1'b0) begin failures++; $display("[TB] FAIL hold_exit got sel=%0b t=%0b exp sel=00 t=0", bus.D_npc_sel, bus.D_taken); end
    checks++; if (taken_cnt !== 16'd1) begin failures++; $display("[TB] FAIL hold_taken_cnt got=%0d exp=1", taken_cnt); end
    next_cycle();
  endtask

  task automatic test_valid_drop();
    do_reset();
    drive(1'b1, 3'b101, 32'h7000, 16'h0, 26'h0, 32'h8000, 32'h0, 1'b0, 1'b0, 1'b0);
    next_cycle();
    drive(1'b0, 3'b101, 32'h7000, 16'h0, 26'h0, 32'h8000, 32'h0, 1'b1, 1'b0, 1'b0);
    checks++; if (bus.D_stall !== 1'b0 || bus.D_taken !== 1'b0 || bus.D_npc_sel !== 2'b00 || bus.D_npc !== 32'h7004) begin failures++; $display("[TB] FAIL drop_wait got st=%0b t=%0b sel=%0b npc=%h exp st=0 t=0 sel=00 npc=00007004", bus.D_stall, bus.D_taken, bus.D_npc_sel, bus.D_npc); end
    next_cycle();
  endtask

  task automatic test_jal_reset();
    do_reset();
    drive(1'b1, 3'b100, 32'h9000_3000, 16'h0, 26'h0000100, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    checks++; if (bus.D_npc_sel !== 2'b10 || bus.D_npc !== 32'h9000_0400 || bus.D_link_we !== 1'b1 || bus.D_stall !== 1'b0) begin failures++; $display("[TB] FAIL jal got sel=%0b npc=%h l=%0b st=%0b exp sel=10 npc=90000400 l=1 st=0", bus.D_npc_sel, bus.D_npc, bus.D_link_we, bus.D_stall); end
    next_cycle();
    drive(1'b1, 3'b101, 32'h9000_3004, 16'h0, 26'h0, 32'h100, 32'h0, 1'b0, 1'b0, 1'b0);
    next_cycle();
    checks++; if (taken_cnt !== 16'd1 || stall_cnt !== 16'd1) begin failures++; $display("[TB] FAIL pre_rst_cnt got=%0d/%0d exp=1/1", taken_cnt, stall_cnt); end
    reset = 1'b1;
    #1;
    checks++; if (bus.D_stall !== 1'b0) begin failures++; $display("[TB] FAIL midwait_rst_stall got=%0b exp=0", bus.D_stall); end
    next_cycle();
    reset = 1'b0;
    drive(1'b0, 3'b000, 32'h9000_3004, 16'h0, 26'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    checks++; if (taken_cnt !== 16'd0 || stall_cnt !== 16'd0 || bus.D_stall !== 1'b0 || bus.D_taken !== 1'b0 || bus.D_link_we !== 1'b0 || bus.D_npc_sel !== 2'b00 || bus.D_err !== 1'b0) begin failures++; $display("[TB] FAIL post_rst got tc=%0d sc=%0d st=%0b t=%0b l=%0b sel=%0b err=%0b exp all zero", taken_cnt, stall_cnt, bus.D_stall, bus.D_taken, bus.D_link_we, bus.D_npc_sel, bus.D_err); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    drive(1'b0, 3'b000, 32'h0, 16'h0, 26'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    next_cycle();
    test_reset();
    test_beq_bne();
    test_bpj();
    test_jr_wait();
    test_wait_overrun();
    test_hold();
    test_valid_drop();
    test_jal_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
